btn_event_counter: RTL and testbench
====================================

Name: btn_event_counter

Overview:
- Parametrised successor to the single-button 0–255 counter that drives the LCD/LED front end.
- Debounces the push-button and counts up, down or automatically at one of two selectable tick rates.
- Maintains the binary count and an N-digit packed-BCD image in lock-step, so the LCD writer needs no binary-to-BCD conversion.
- Sits between board inputs (btn/stop/speed/mode) and the LCD controller and LED bank.

Parameters:
- DIGITS, 3: number of BCD digits output; requires 10^DIGITS > MAX_COUNT.
- MAX_COUNT, 255: terminal count; wrap boundary in both directions.
- CNT_W, 8: width of the binary count q; requires 2^CNT_W > MAX_COUNT.
- DEB_CYCLES, 4: consecutive stable synchronised samples required to accept a new button level; must be ≥ 1.
- TICK_SLOW, 50_000_000: clk cycles per auto-count step when speed=0; must be ≥ 1.
- TICK_FAST, 12_500_000: clk cycles per auto-count step when speed=1; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- btn  input  1  raw asynchronous push-button.
- stop  input  1  freeze: no count changes while high.
- speed  input  1  auto-mode rate select: 0=TICK_SLOW, 1=TICK_FAST.
- mode  input  2  00 hold, 01 manual up, 10 manual down, 11 auto up.
- q  output  CNT_W  binary count.
- bcd  output  4*DIGITS  packed BCD of q; digit 0 (ones) in [3:0].
- LED  output  8  q zero-extended or truncated to 8 bits.
- wrap_p  output  1  one-cycle pulse on any wrap.
- btn_evt  output  1  one-cycle pulse per accepted button press, in every mode.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - q=0, bcd=0, LED=0, wrap_p=0, btn_evt=0.
  - Synchroniser FFs, debounced level, debounce counter and tick counter all cleared.
  - Reset overrides every other input in the same cycle, including mid-debounce and mid-tick.
- Synchroniser: 2-FF synchroniser on btn yields btn_s.
- Debounce:
  - Counter increments while btn_s ≠ debounced level; clears when btn_s = debounced level.
  - On reaching DEB_CYCLES, debounced level takes btn_s and the counter clears.
  - btn_evt pulses for one cycle on each 0→1 transition of the debounced level.
  - A glitch shorter than DEB_CYCLES cycles produces no event.
- Step request (evaluated at each clk edge, using the current mode):
  - 01: up step on btn_evt.
  - 10: down step on btn_evt.
  - 11: up step on tick; btn_evt is ignored.
  - 00: no step.
  - stop=1 suppresses every step. btn_evt still pulses but is discarded, not queued.
- Tick counter:
  - Runs only when mode=11 and stop=0; otherwise held at 0.
  - Tick is asserted when the count equals the period minus 1 (period = TICK_FAST if speed else TICK_SLOW); counter returns to 0 on that cycle.
  - If speed changes mid-period and the counter is already ≥ the new period minus 1, the tick fires next cycle.
- Up step: q = (q == MAX_COUNT) ? 0 : q+1.
- Down step: q = (q == 0) ? MAX_COUNT : q-1.
- wrap_p is asserted in the same cycle q takes its wrapped value.
- bcd:
  - Updated in the same cycle as q, by digit-wise ripple increment/decrement (9→0 carry, 0→9 borrow).
  - On wrap, bcd loads 0 (up) or the constant BCD(MAX_COUNT) (down).
  - Invariant: bcd == BCD(q) on every cycle.
- Latency:
  - btn sampled high at edge k with stable input → btn_evt high after edge k+2+DEB_CYCLES.
  - The step is applied at the next edge; q and bcd are registered outputs.
- Mode change: takes effect on the edge where it is first sampled. A btn_evt coinciding with that edge uses the new mode.
- LED: registered copy of q, same-cycle update as q.

Decomposition:
- Shared package (lcd_kit_pkg):
  - Mode encodings MODE_HOLD / MODE_UP / MODE_DOWN / MODE_AUTO.
  - BCD digit width constant (4).
  - Function computing the BCD image of a constant, used for the MAX_COUNT wrap load.
- One sub-module: btn_debounce (synchroniser, debounce counter, rising-edge pulse; parameter DEB_CYCLES).

Test Plan:
- Reset, then mode=01 with 3 clean presses, each held 10 cycles (DEB_CYCLES=4) → q=3, bcd=0x003, LED=0x03, 3 btn_evt pulses, wrap_p never high.
- mode=01, btn glitch high 2 cycles → no btn_evt, q unchanged. Then hold 6 cycles → exactly one increment, at edge 2+4+1 after first high sample.
- Preload to q=255 via presses, one more up press → q=0, bcd=0x000, wrap_p one pulse. Then mode=10 with one press → q=255, bcd=0x255, wrap_p pulse.
- mode=11, TICK_SLOW=8, TICK_FAST=2, speed=0 for 40 cycles → q=5. Switch speed=1 for 10 cycles → q=10. Press btn meanwhile → no extra count.
- mode=11, stop=1 for 30 cycles → q frozen, tick counter 0. Release → next step exactly TICK period later.
- reset asserted mid-debounce (btn high 2 cycles) and with q=137 → next cycle all outputs 0. Continued btn high produces an event only after a full 2+DEB_CYCLES from reset release.

Source files
------------

// File: rtl/lcd_kit_pkg.sv
// Shared definitions for the LCD/LED front-end counter blocks: mode encodings,
// BCD digit width and a constant-evaluable binary-to-BCD helper.
package lcd_kit_pkg;

  localparam int BCD_W          = 4;
  localparam int BCD_MAX_DIGITS = 16;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_AUTO = 2'b11
  } mode_e;

  // Elaboration-time only: builds wrap-load constants, never used on live data.
  function automatic logic [BCD_W*BCD_MAX_DIGITS-1:0] bcd_image(input longint unsigned value);
    logic [BCD_W*BCD_MAX_DIGITS-1:0] img;
    longint unsigned                 v;
    img = '0;
    v   = value;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      img[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return img;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted press (debounced 0->1).
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_evt
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             btn_s;
  logic [DEB_W-1:0] cnt_reg;
  logic             level_reg;
  logic             prev_level_reg;
  logic             evt_reg;

  assign btn_s   = sync_reg[1];
  assign btn_evt = evt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg       <= '0;
      cnt_reg        <= '0;
      level_reg      <= 1'b0;
      prev_level_reg <= 1'b0;
      evt_reg        <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], btn};
      prev_level_reg <= level_reg;
      evt_reg        <= level_reg & ~prev_level_reg;
      // Any sample that agrees with the accepted level restarts the stability window.
      if (btn_s != level_reg) begin
        if (cnt_reg == DEB_LAST) begin
          level_reg <= btn_s;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + DEB_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/btn_event_counter.sv
// Button/auto driven up-down counter with wrap at MAX_COUNT, keeping a packed
// BCD image in lock-step with the binary count for the LCD writer.
module btn_event_counter
  import lcd_kit_pkg::*;
#(
  parameter int DIGITS     = 3,
  parameter int MAX_COUNT  = 255,
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 4,
  parameter int TICK_SLOW  = 50_000_000,
  parameter int TICK_FAST  = 12_500_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn,
  input  logic                    stop,
  input  logic                    speed,
  input  logic [1:0]              mode,
  output logic [CNT_W-1:0]        q,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic [7:0]              LED,
  output logic                    wrap_p,
  output logic                    btn_evt
);

  localparam int TICK_MAX = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BCD_TW   = BCD_W * DIGITS;

  localparam logic [TICK_W-1:0] SLOW_M1 = TICK_W'(TICK_SLOW - 1);
  localparam logic [TICK_W-1:0] FAST_M1 = TICK_W'(TICK_FAST - 1);
  localparam logic [CNT_W-1:0]  Q_MAX   = CNT_W'(MAX_COUNT);
  localparam logic [BCD_W*BCD_MAX_DIGITS-1:0] BCD_MAX_ALL = bcd_image(MAX_COUNT);
  localparam logic [BCD_TW-1:0] BCD_MAX = BCD_MAX_ALL[BCD_TW-1:0];

  logic              evt;
  logic              tick_run;
  logic              tick;
  logic [TICK_W-1:0] period_m1;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [TICK_W-1:0] tick_cnt_next;
  logic              step_up;
  logic              step_dn;

  logic [CNT_W-1:0]  q_reg,   q_next;
  logic [BCD_TW-1:0] bcd_reg, bcd_next;
  logic [7:0]        led_reg, led_next;
  logic              wrap_reg, wrap_next;

  logic [BCD_TW-1:0] bcd_inc;
  logic [BCD_TW-1:0] bcd_dec;
  logic [DIGITS-1:0] inc_carry;
  logic [DIGITS-1:0] dec_borrow;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .btn_evt(evt)
  );

  // Ripple +1 / -1 on the BCD image; only the low digit is unconditionally touched.
  assign inc_carry[0]  = 1'b1;
  assign dec_borrow[0] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [BCD_W-1:0] digit;
    assign digit = bcd_reg[gi*BCD_W +: BCD_W];

    assign bcd_inc[gi*BCD_W +: BCD_W] = !inc_carry[gi]   ? digit :
                                        (digit == 4'd9)  ? 4'd0  : digit + 4'd1;
    assign bcd_dec[gi*BCD_W +: BCD_W] = !dec_borrow[gi]  ? digit :
                                        (digit == 4'd0)  ? 4'd9  : digit - 4'd1;

    if (gi < DIGITS - 1) begin : g_chain
      assign inc_carry[gi+1]  = inc_carry[gi]  && (digit == 4'd9);
      assign dec_borrow[gi+1] = dec_borrow[gi] && (digit == 4'd0);
    end
  end

  always_comb begin
    tick_run  = (mode_e'(mode) == MODE_AUTO) && !stop;
    period_m1 = speed ? FAST_M1 : SLOW_M1;
    // >= so a fast-rate switch past the new terminal value fires immediately.
    tick      = tick_run && (tick_cnt_reg >= period_m1);
    step_up   = !stop && (((mode_e'(mode) == MODE_UP) && evt) || tick);
    step_dn   = !stop && (mode_e'(mode) == MODE_DOWN) && evt;

    tick_cnt_next = (!tick_run || tick) ? '0 : tick_cnt_reg + TICK_W'(1);

    q_next    = q_reg;
    bcd_next  = bcd_reg;
    wrap_next = 1'b0;
    if (step_up) begin
      if (q_reg == Q_MAX) begin
        q_next    = '0;
        bcd_next  = '0;
        wrap_next = 1'b1;
      end else begin
        q_next   = q_reg + CNT_W'(1);
        bcd_next = bcd_inc;
      end
    end else if (step_dn) begin
      if (q_reg == '0) begin
        q_next    = Q_MAX;
        bcd_next  = BCD_MAX;
        wrap_next = 1'b1;
      end else begin
        q_next   = q_reg - CNT_W'(1);
        bcd_next = bcd_dec;
      end
    end
    led_next = 8'(q_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_reg <= '0;
      q_reg        <= '0;
      bcd_reg      <= '0;
      led_reg      <= '0;
      wrap_reg     <= 1'b0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
      q_reg        <= q_next;
      bcd_reg      <= bcd_next;
      led_reg      <= led_next;
      wrap_reg     <= wrap_next;
    end
  end

  assign q       = q_reg;
  assign bcd     = bcd_reg;
  assign LED     = led_reg;
  assign wrap_p  = wrap_reg;
  assign btn_evt = evt;

endmodule

// File: tb/tb_btn_event_counter.sv
// Directed bench for btn_event_counter: debounce latency, manual up/down wrap,
// auto tick rates, stop freeze and reset in the middle of a debounce.
module tb_btn_event_counter;

  localparam int DIGITS     = 3;
  localparam int MAX_COUNT  = 255;
  localparam int CNT_W      = 8;
  localparam int DEB_CYCLES = 4;
  localparam int TICK_SLOW  = 8;
  localparam int TICK_FAST  = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        btn   = 1'b0;
  logic        stop  = 1'b0;
  logic        speed = 1'b0;
  logic [1:0]  mode  = 2'b00;
  logic [7:0]  q;
  logic [11:0] bcd;
  logic [7:0]  led;
  logic        wrap_p;
  logic        btn_evt;

  int total    = 0;
  int passed   = 0;
  int failed   = 0;
  int evt_cnt  = 0;
  int wrap_cnt = 0;
  int evt_base = 0;
  bit mon_on   = 1'b0;

  always #5 clk = ~clk;

  btn_event_counter #(
    .DIGITS    (DIGITS),
    .MAX_COUNT (MAX_COUNT),
    .CNT_W     (CNT_W),
    .DEB_CYCLES(DEB_CYCLES),
    .TICK_SLOW (TICK_SLOW),
    .TICK_FAST (TICK_FAST)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .stop   (stop),
    .speed  (speed),
    .mode   (mode),
    .q      (q),
    .bcd    (bcd),
    .LED    (led),
    .wrap_p (wrap_p),
    .btn_evt(btn_evt)
  );

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int hold, input int gap);
    btn = 1'b1;
    step(hold);
    btn = 1'b0;
    step(gap);
  endtask

  // Per-cycle pulse tally plus the BCD/LED relationship to q.
  always @(negedge clk) begin
    if (mon_on) begin
      if (btn_evt) evt_cnt++;
      if (wrap_p)  wrap_cnt++;
      check("bcd_tracks_q", {20'd0, bcd}, {20'd0, ref_bcd(int'(q))});
      check("led_tracks_q", {24'd0, led}, {24'd0, q});
    end
  end

  initial begin
    // Reset state
    step(2);
    check("rst_q", q, 0);
    check("rst_bcd", bcd, 0);
    check("rst_led", led, 0);
    check("rst_wrap", wrap_p, 0);
    check("rst_evt", btn_evt, 0);
    reset  = 1'b0;
    mode   = 2'b01;
    mon_on = 1'b1;
    step(1);
    $display("txn reset: q=%0d bcd=%03h", q, bcd);

    // Three clean presses in manual up
    for (int i = 0; i < 3; i++) press(10, 10);
    check("up3_q", q, 3);
    check("up3_bcd", bcd, 12'h003);
    check("up3_led", led, 8'h03);
    check("up3_evts", evt_cnt, 3);
    check("up3_wraps", wrap_cnt, 0);
    $display("txn 3 presses: q=%0d bcd=%03h evts=%0d", q, bcd, evt_cnt);

    // Two-cycle glitch is rejected
    press(2, 10);
    check("glitch_q", q, 3);
    check("glitch_evts", evt_cnt, 3);
    $display("txn glitch: q=%0d evts=%0d", q, evt_cnt);

    // Six-cycle press: event after edge k+6, step at k+7
    btn = 1'b1;
    step(6);
    btn = 1'b0;
    check("lat_evt_early", btn_evt, 0);
    check("lat_q_early", q, 3);
    step(1);
    check("lat_evt", btn_evt, 1);
    check("lat_q_hold", q, 3);
    step(1);
    check("lat_q_step", q, 4);
    check("lat_evt_end", btn_evt, 0);
    step(10);
    check("lat_evts", evt_cnt, 4);
    $display("txn timed press: q=%0d evts=%0d", q, evt_cnt);

    // Preload to MAX_COUNT then wrap upward
    for (int i = 0; i < 251; i++) press(8, 8);
    check("pre_q", q, 255);
    check("pre_bcd", bcd, 12'h255);
    check("pre_led", led, 8'hFF);
    check("pre_wraps", wrap_cnt, 0);
    btn = 1'b1;
    step(8);
    check("upwrap_q", q, 0);
    check("upwrap_bcd", bcd, 12'h000);
    check("upwrap_pulse", wrap_p, 1);
    step(1);
    check("upwrap_pulse_end", wrap_p, 0);
    btn = 1'b0;
    step(10);
    check("upwrap_count", wrap_cnt, 1);
    $display("txn up wrap: q=%0d bcd=%03h wraps=%0d", q, bcd, wrap_cnt);

    // Manual down wraps 0 -> MAX_COUNT
    mode = 2'b10;
    btn  = 1'b1;
    step(8);
    check("dnwrap_q", q, 255);
    check("dnwrap_bcd", bcd, 12'h255);
    check("dnwrap_led", led, 8'hFF);
    check("dnwrap_pulse", wrap_p, 1);
    btn = 1'b0;
    step(10);
    check("dnwrap_count", wrap_cnt, 2);
    $display("txn down wrap: q=%0d bcd=%03h wraps=%0d", q, bcd, wrap_cnt);

    // Auto mode: slow rate 8 cycles/step, then fast rate 2 cycles/step
    reset = 1'b1;
    mode  = 2'b00;
    step(1);
    reset = 1'b0;
    mode  = 2'b11;
    speed = 1'b0;
    step(39);
    check("slow_q39", q, 4);
    step(1);
    check("slow_q40", q, 5);
    check("slow_bcd", bcd, 12'h005);
    speed    = 1'b1;
    btn      = 1'b1;
    evt_base = evt_cnt;
    step(10);
    check("fast_q", q, 10);
    check("fast_bcd", bcd, 12'h010);
    check("auto_btn_evt_seen", evt_cnt, evt_base + 1);
    btn = 1'b0;
    $display("txn auto: q=%0d bcd=%03h", q, bcd);

    // Stop freezes and clears the tick counter
    stop  = 1'b1;
    speed = 1'b0;
    step(30);
    check("stop_q", q, 10);
    stop = 1'b0;
    step(7);
    check("resume_q7", q, 10);
    step(1);
    check("resume_q8", q, 11);
    // Switch to fast once counter is already past the fast terminal value
    step(5);
    check("midspeed_q_before", q, 11);
    speed = 1'b1;
    step(1);
    check("midspeed_q_after", q, 12);
    $display("txn stop/resume: q=%0d", q);

    // Reach 137, then reset in the middle of a debounce
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(274);
    mode = 2'b00;
    check("pre137_q", q, 137);
    check("pre137_bcd", bcd, 12'h137);
    check("pre137_led", led, 8'h89);
    step(2);
    check("hold137_q", q, 137);
    btn = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    check("midrst_q", q, 0);
    check("midrst_bcd", bcd, 0);
    check("midrst_led", led, 0);
    check("midrst_wrap", wrap_p, 0);
    check("midrst_evt", btn_evt, 0);
    reset    = 1'b0;
    evt_base = evt_cnt;
    step(6);
    check("postrst_evt_early", btn_evt, 0);
    check("postrst_evts_early", evt_cnt, evt_base);
    step(1);
    check("postrst_evt", btn_evt, 1);
    check("postrst_q", q, 0);
    btn = 1'b0;
    step(10);
    $display("txn reset mid-debounce: q=%0d evts=%0d", q, evt_cnt);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
